// File: rtl/core_ctrl.sv
// Multi-cycle sequencing FSM for the RV32I core: fetch/decode/exec/mem/wb control and instret.
// Optional macro CORE_CTRL_ILLEGAL_TRAP_EN traps unlisted opcodes with illegal=1 instead of running them as no-ops.
module core_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             bus_ready,
    output logic             bus_req,
    output logic             bus_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             halt,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;

    // funct3 only rides along to the bus width logic elsewhere; it never steers sequencing.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    function automatic logic is_listed(input logic [6:0] op);
        case (op)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_MISC_MEM, OPC_SYSTEM: is_listed = 1'b1;
            default:                                      is_listed = 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Outputs are forced low while resetn is low so a reset mid-request drops bus_req at once.
    always_comb begin
        state_d  = state_q;
        bus_req  = 1'b0;
        bus_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        retire   = 1'b0;
        halt     = 1'b0;
        illegal  = 1'b0;
        if (resetn) begin
            case (state_q)
                S_FETCH: begin
                    bus_req = 1'b1;
                    if (bus_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    case (opcode)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                            rf_we   = 1'b1;
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        OPC_JAL, OPC_JALR: begin
                            rf_we   = 1'b1;
                            wb_sel  = 2'd2;
                            pc_we   = 1'b1;
                            pc_sel  = (opcode == OPC_JALR) ? 2'd2 : 2'd1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        OPC_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_sel  = {1'b0, branch_taken};
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        OPC_LOAD, OPC_STORE: state_d = S_MEM;
                        OPC_SYSTEM:          state_d = S_TRAP;
                        OPC_MISC_MEM: begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
                            state_d = S_TRAP;
`else
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    bus_req  = 1'b1;
                    addr_sel = 1'b1;
                    bus_we   = (opcode == OPC_STORE);
                    if (bus_ready) begin
                        if (opcode == OPC_STORE) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            mdr_we  = 1'b1;
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    wb_sel  = 2'd1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    halt = 1'b1;
                    // IR is frozen in TRAP, so the trapping opcode is still on the input.
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
                    illegal = !is_listed(opcode);
`endif
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: per-cycle vector table through a scoreboard queue, plus reset/trap sequences.
// A second 3-bit-counter instance shares all inputs so the instret wrap is reached quickly.
module tb_core_ctrl;

    typedef struct packed {
        logic       breq, bwe, asel, irwe, mdrwe, pcwe;
        logic [1:0] pcsel;
        logic       rfwe;
        logic [1:0] wbsel;
        logic       ret, hlt, ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       br;
        logic       rdy;
        logic [2:0] st;
        outs_t      o;
    } row_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken, bus_ready;
    logic        bus_req, bus_we, addr_sel, ir_we, mdr_we, pc_we, rf_we, retire, halt, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;

    logic        s_bus_req, s_bus_we, s_addr_sel, s_ir_we, s_mdr_we, s_pc_we, s_rf_we;
    logic        s_retire, s_halt, s_illegal;
    logic [1:0]  s_pc_sel, s_wb_sel;
    logic [2:0]  s_instret, s_state;

    outs_t act;
    assign act = {bus_req, bus_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, rf_we, wb_sel,
                  retire, halt, illegal};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_instret;
    row_t        rows[$];
    row_t        sb_q[$];

    always #5 clk = ~clk;

    core_ctrl u_dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .bus_ready(bus_ready),
        .bus_req(bus_req), .bus_we(bus_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .retire(retire), .halt(halt), .illegal(illegal), .instret(instret), .state(state)
    );

    core_ctrl #(.CNT_W(3)) u_small (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .bus_ready(bus_ready),
        .bus_req(s_bus_req), .bus_we(s_bus_we), .addr_sel(s_addr_sel), .ir_we(s_ir_we),
        .mdr_we(s_mdr_we), .pc_we(s_pc_we), .pc_sel(s_pc_sel), .rf_we(s_rf_we),
        .wb_sel(s_wb_sel), .retire(s_retire), .halt(s_halt), .illegal(s_illegal),
        .instret(s_instret), .state(s_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void add(input logic [6:0] op, input int br, input int rdy, input int st,
                                input int breq, input int bwe, input int asel, input int irwe,
                                input int mdrwe, input int pcwe, input int pcsel, input int rfwe,
                                input int wbsel, input int ret, input int hlt, input int ill);
        row_t r;
        r.op = op; r.br = br[0]; r.rdy = rdy[0]; r.st = st[2:0];
        r.o = {breq[0], bwe[0], asel[0], irwe[0], mdrwe[0], pcwe[0], pcsel[1:0], rfwe[0],
               wbsel[1:0], ret[0], hlt[0], ill[0]};
        rows.push_back(r);
    endfunction

    // Called at posedge+1: drive one cycle of inputs, sample at the following negedge.
    task automatic run_rows(input string tag);
        row_t r, e;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            opcode = r.op; branch_taken = r.br; bus_ready = r.rdy; funct3 = 3'($urandom_range(7));
            sb_q.push_back(r);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL %s_sb: scoreboard empty", tag);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_outs"}, 32'(act), 32'(e.o));
                check({tag, "_state"}, 32'(state), 32'(e.st));
                check({tag, "_instret"}, instret, exp_instret);
                check({tag, "_instret_w3"}, 32'(s_instret), 32'(exp_instret[2:0]));
                if (e.o.ret) exp_instret++;
            end
            @(posedge clk); #1;
        end
    endtask

    localparam logic [6:0] ADDI = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, FENCE = 7'b0001111, SYS = 7'b1110011;
    localparam logic [6:0] OPC0 = 7'b0000000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; bus_ready = 1'b1; opcode = ADDI; funct3 = 3'd0; branch_taken = 1'b0;
        exp_instret = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_bus_req", 32'(bus_req), 32'd0);
            check("rst_outs", 32'(act), 32'd0);
            check("rst_state", 32'(state), 32'd0);
            check("rst_instret", instret, 32'd0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        // columns: op br rdy st | breq bwe asel irwe mdrwe pcwe pcsel rfwe wbsel ret hlt ill
        add(ADDI, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(ADDI, 0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(ADDI, 0,1,2, 0,0,0,0,0,1,0,1,0,1,0,0);
        // load with two MEM wait cycles: 7 cycles total
        add(LOAD, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(LOAD, 0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(LOAD, 0,0,2, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(LOAD, 0,0,3, 1,0,1,0,0,0,0,0,0,0,0,0);
        add(LOAD, 0,0,3, 1,0,1,0,0,0,0,0,0,0,0,0);
        add(LOAD, 0,1,3, 1,0,1,0,1,0,0,0,0,0,0,0);
        add(LOAD, 0,1,4, 0,0,0,0,0,1,0,1,1,1,0,0);
        add(STORE,0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(STORE,0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(STORE,0,1,2, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(STORE,0,1,3, 1,1,1,0,0,1,0,0,0,1,0,0);
        add(BR,   1,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(BR,   1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(BR,   1,1,2, 0,0,0,0,0,1,1,0,0,1,0,0);
        add(BR,   0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(BR,   0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(BR,   0,1,2, 0,0,0,0,0,1,0,0,0,1,0,0);
        add(JAL,  0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(JAL,  0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(JAL,  0,1,2, 0,0,0,0,0,1,1,1,2,1,0,0);
        add(JALR, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(JALR, 0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(JALR, 0,1,2, 0,0,0,0,0,1,2,1,2,1,0,0);
        // fetch wait cycle, then ordinary LUI and FENCE
        add(LUI,  0,0,0, 1,0,0,0,0,0,0,0,0,0,0,0);
        add(LUI,  0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(LUI,  0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(LUI,  0,1,2, 0,0,0,0,0,1,0,1,0,1,0,0);
        add(FENCE,0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(FENCE,0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(FENCE,0,1,2, 0,0,0,0,0,1,0,0,0,1,0,0);
        add(ADDI, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(ADDI, 0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(ADDI, 0,1,2, 0,0,0,0,0,1,0,1,0,1,0,0);
        run_rows("seq");
        check("instret_after_seq", instret, 32'd10);
        check("instret_w3_wrapped", 32'(s_instret), 32'd2);

        add(SYS, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(SYS, 0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(SYS, 0,1,2, 0,0,0,0,0,0,0,0,0,0,0,0);
        for (int i = 0; i < 10; i++) add(SYS, 0,1,5, 0,0,0,0,0,0,0,0,0,0,1,0);
        run_rows("sys");

        // reset out of TRAP, then reset again in the middle of a stalled fetch
        resetn = 1'b0; #1;
        check("trap_rst_state", 32'(state), 32'd0);
        check("trap_rst_halt", 32'(halt), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1; exp_instret = 32'd0;
        add(ADDI, 0,0,0, 1,0,0,0,0,0,0,0,0,0,0,0);
        run_rows("stall");
        check("stall_bus_req", 32'(bus_req), 32'd1);
        resetn = 1'b0; #1;
        check("midbus_rst_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        add(OPC0, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
        add(OPC0, 0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0);
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
        add(OPC0, 0,1,2, 0,0,0,0,0,0,0,0,0,0,0,0);
        add(OPC0, 0,1,5, 0,0,0,0,0,0,0,0,0,0,1,1);
        add(OPC0, 0,1,5, 0,0,0,0,0,0,0,0,0,0,1,1);
`else
        add(OPC0, 0,1,2, 0,0,0,0,0,1,0,0,0,1,0,0);
        add(OPC0, 0,1,0, 1,0,0,1,0,0,0,0,0,0,0,0);
`endif
        run_rows("opc0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle sequencing FSM for the RV32I core.
- Takes the opcode and funct3 fields produced by the instruction decoder, plus a branch-compare result and a memory-bus acknowledge.
- Drives the enables and mux selects for the instruction register, PC, register file, memory data register and shared memory bus.
- Keeps a retired-instruction counter and halts on SYSTEM instructions.

Parameters:
- CNT_W, 32, width of the instret counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- opcode  input  7  decoded opcode field (inst[6:0] of IR).
- funct3  input  3  decoded funct3; not used for sequencing, carried for the store/load width on the bus.
- branch_taken  input  1  ALU compare result for the current BRANCH.
- bus_ready  input  1  memory acknowledge; completes the current bus_req cycle.
- bus_req  output  1  memory request; held until bus_ready.
- bus_we  output  1  1 = store; valid while bus_req.
- addr_sel  output  1  0 = PC, 1 = ALU result (load/store address).
- ir_we  output  1  latch bus read data into IR.
- mdr_we  output  1  latch bus read data into memory data register.
- pc_we  output  1  update PC this cycle.
- pc_sel  output  2  0 = PC+4, 1 = PC+imm (JAL/taken branch), 2 = rs1+imm with bit0 cleared (JALR).
- rf_we  output  1  register file write enable.
- wb_sel  output  2  0 = ALU, 1 = MDR, 2 = PC+4.
- retire  output  1  one-cycle pulse when an instruction completes.
- halt  output  1  core halted (TRAP state).
- illegal  output  1  halted due to an illegal opcode.
- instret  output  CNT_W  retired-instruction count.
- state  output  3  current FSM state, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Only the state and instret are registered; all other outputs decode combinationally from state, opcode, branch_taken and bus_ready.
- Reset: resetn low forces state=FETCH and instret=0, and drives every combinational output to 0, including bus_req. Reset mid-bus-cycle drops bus_req immediately. The first request is issued in the first cycle after resetn rises.
- FETCH: bus_req=1, addr_sel=0, bus_we=0. On bus_ready, ir_we=1 and the next state is DECODE; otherwise stay in FETCH.
- DECODE: one settle cycle with no enables; the next state is EXEC.
- EXEC, dispatched on opcode:
  - OP (0110011), OP_IMM (0010011), LUI (0110111), AUIPC (0010111): rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, retire=1; go to FETCH.
  - JAL (1101111): rf_we=1, wb_sel=2, pc_we=1, pc_sel=1, retire=1; go to FETCH.
  - JALR (1100111): as JAL but pc_sel=2.
  - BRANCH (1100011): pc_we=1, pc_sel=branch_taken?1:0, retire=1, no rf_we; go to FETCH.
  - LOAD (0000011), STORE (0100011): no enables; go to MEM.
  - MISC_MEM (0001111): treated as a no-op: pc_we=1, pc_sel=0, retire=1; go to FETCH.
  - SYSTEM (1110011): go to TRAP with no retire and no pc_we.
  - Any other opcode: see Optional Feature.
- MEM: bus_req=1, addr_sel=1, bus_we=(opcode==STORE). On bus_ready:
  - store: pc_we=1, pc_sel=0, retire=1; go to FETCH.
  - load: mdr_we=1; go to WB.
  - Without bus_ready, hold all MEM outputs stable.
- WB: rf_we=1, wb_sel=1, pc_we=1, pc_sel=0, retire=1; go to FETCH.
- TRAP: halt=1, all other enables 0, no bus requests. TRAP is exited only by reset.
- Latency with zero-wait memory (bus_ready high on the first request cycle):
  - ALU, jump, branch and fence: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- instret increments by 1 on every cycle where retire=1 and wraps from all-ones to 0.
- bus_ready while not in FETCH or MEM is ignored.
- retire and halt are never asserted together.

Optional Feature:
- Macro: CORE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in EXEC, including any opcode with [1:0]!=2'b11, goes to TRAP and sets illegal=1. illegal stays set with halt until reset, and the instruction does not retire.
- Undefined: an unlisted opcode is executed as a no-op (pc_we=1, pc_sel=0, retire=1, go to FETCH). illegal is tied to 0.

Test Plan:
- resetn low for 3 cycles, then released, with bus_ready=1 -> bus_req=0 during reset; state=0 and bus_req=1 on the first cycle after release; ir_we pulses in that same cycle.
- ADDI (opcode 0010011) with bus_ready held high -> state sequence 0,1,2,0; in EXEC rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, retire=1; instret 0->1.
- LOAD with bus_ready low for 2 MEM cycles then high -> bus_req=1, addr_sel=1, bus_we=0 held for 3 cycles; mdr_we on the acknowledge cycle; WB asserts rf_we=1, wb_sel=1; total 7 cycles.
- BRANCH with branch_taken=1, then again with branch_taken=0 -> pc_sel=1, then pc_sel=0; rf_we=0 both times; instret advances by 2.
- SYSTEM opcode 1110011 -> state=5, halt=1; no further bus_req for 10 cycles; instret unchanged; resetn pulse returns state to 0.
- Opcode 0000000 -> with the macro defined, halt=1 and illegal=1; without it, retire=1, pc_sel=0, illegal=0. Separately, preload instret=0xFFFFFFFF and retire once -> instret=0.
